// File: rtl/tea_pkg.sv
`default_nettype none
// tea_pkg: shared constants, block type, serializer states and byte-lane mapping for the TEA feeder.
// Byte order is selected by TEA_FEEDER_BE_EN (defined: big-endian, undefined: little-endian).
package tea_pkg;
   localparam logic [31:0] DELTA_CONST = 32'h9E3779B9;
   localparam int          CYCLE_NUM   = 32;
   localparam int          TEA_LAT     = 33;

   typedef struct packed {
      logic [31:0] v0;
      logic [31:0] v1;
   } tea_block_t;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } ser_state_t;

   // LSB position of stream byte idx inside a packed tea_block_t ({v0, v1}).
   function automatic logic [5:0] byte_lsb(input logic [2:0] idx);
`ifdef TEA_FEEDER_BE_EN
      return 6'd56 - {idx, 3'b000};
`else
      return idx[2] ? {1'b0, idx[1:0], 3'b000} : {1'b1, idx[1:0], 3'b000};
`endif
   endfunction
endpackage
`default_nettype wire

// File: rtl/tea_byte_serializer.sv
`default_nettype none
// tea_byte_serializer: pops one result word when idle and streams it out byte by byte,
// returning a credit on the final byte handshake. Byte order follows TEA_FEEDER_BE_EN.
module tea_byte_serializer
   import tea_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  tea_block_t word_i,
   input  logic       empty_i,
   output logic       pop_o,
   output logic [7:0] byte_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       credit_o,
   output logic       active_o
);
   ser_state_t state_q;
   logic [2:0] idx_q;
   tea_block_t word_q;

   assign valid_o  = (state_q == S_SEND);
   assign active_o = valid_o;
   assign pop_o    = (state_q == S_IDLE) && !empty_i;
   assign byte_o   = valid_o ? word_q[byte_lsb(idx_q) +: 8] : 8'h00;
   assign credit_o = valid_o && ready_i && (idx_q == 3'd7);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         word_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty_i) begin
                  word_q  <= word_i;
                  idx_q   <= 3'd0;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (ready_i) begin
                  idx_q <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/tea_stream_feeder.sv
`default_nettype none
// tea_stream_feeder: packs bytes into 64-bit blocks for the free-running TEA core, tracks them
// through the core latency and streams credit-protected results back out. Byte order: TEA_FEEDER_BE_EN.
module tea_stream_feeder #(
   parameter int TEA_LAT    = tea_pkg::TEA_LAT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] tea_v0_in,
   output logic [31:0] tea_v1_in,
   input  logic [31:0] tea_v0_out,
   input  logic [31:0] tea_v1_out,
   output logic        busy
);
   import tea_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(FIFO_DEPTH - 1);

   logic [2:0]         bcnt_q;
   logic               complete_q;
   logic [63:0]        pack_q;
   tea_block_t         v_in_q;
   logic               issued_q;
   logic [TEA_LAT-1:0] dly_q;
   logic [CNT_W-1:0]   credits_q;
   tea_block_t         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;

   logic w_accept;
   logic w_issue;
   logic w_fifo_wr;
   logic w_fifo_rd;
   logic w_credit;
   logic w_ser_active;

   assign in_ready  = !complete_q;
   assign w_accept  = in_valid && !complete_q;
   assign w_issue   = complete_q && (credits_q != '0);
   assign w_fifo_wr = dly_q[TEA_LAT-1];
   assign tea_v0_in = v_in_q.v0;
   assign tea_v1_in = v_in_q.v1;
   assign busy      = (bcnt_q != 3'd0) || complete_q || issued_q || (|dly_q)
                      || (cnt_q != '0) || w_ser_active;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         bcnt_q     <= 3'd0;
         complete_q <= 1'b0;
         pack_q     <= '0;
      end else if (w_accept) begin
         pack_q[byte_lsb(bcnt_q) +: 8] <= in_byte;
         bcnt_q <= bcnt_q + 3'd1;
         if (bcnt_q == 3'd7) begin
            complete_q <= 1'b1;
         end
      end else if (w_issue) begin
         complete_q <= 1'b0;
      end
   end

   // issued_q marks a live block on tea_v*_in; dly_q then ages it to the core output.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v_in_q    <= '0;
         issued_q  <= 1'b0;
         dly_q     <= '0;
         credits_q <= c_depth;
      end else begin
         if (w_issue) begin
            v_in_q <= tea_block_t'(pack_q);
         end else begin
            v_in_q <= '0;
         end
         issued_q  <= w_issue;
         dly_q     <= {dly_q[TEA_LAT-2:0], issued_q};
         credits_q <= credits_q - CNT_W'(w_issue) + CNT_W'(w_credit);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (w_fifo_wr) begin
            mem_q[wr_ptr_q] <= {tea_v0_out, tea_v1_out};
            wr_ptr_q <= (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (w_fifo_rd) begin
            rd_ptr_q <= (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         cnt_q <= cnt_q + CNT_W'(w_fifo_wr) - CNT_W'(w_fifo_rd);
      end
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (!nrst)
      !(w_fifo_wr && (cnt_q == c_depth)));
   credit_in_range: assert property (@(posedge clk) disable iff (!nrst)
      !(w_credit && !w_issue && (credits_q == c_depth)));

   tea_byte_serializer u_ser (
      .clk      (clk),
      .nrst     (nrst),
      .word_i   (mem_q[rd_ptr_q]),
      .empty_i  (cnt_q == '0),
      .pop_o    (w_fifo_rd),
      .byte_o   (out_byte),
      .valid_o  (out_valid),
      .ready_i  (out_ready),
      .credit_o (w_credit),
      .active_o (w_ser_active)
   );
endmodule
`default_nettype wire

// File: tb/tb_tea_stream_feeder.sv
`default_nettype none
// tb_tea_stream_feeder: directed checks of packing, issue/credit flow, serialization and reset,
// driving the feeder against a behavioural key-0 TEA core. Byte order follows TEA_FEEDER_BE_EN.
module tb_tea_stream_feeder;
   localparam int TEA_LAT    = 33;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        nrst;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] tea_v0_in;
   logic [31:0] tea_v1_in;
   logic [31:0] tea_v0_out;
   logic [31:0] tea_v1_out;
   logic        busy;

   always #5 clk = ~clk;

   tea_stream_feeder #(.TEA_LAT(TEA_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .in_byte    (in_byte),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_byte   (out_byte),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .tea_v0_in  (tea_v0_in),
      .tea_v1_in  (tea_v1_in),
      .tea_v0_out (tea_v0_out),
      .tea_v1_out (tea_v1_out),
      .busy       (busy)
   );

   function automatic logic [63:0] tea_enc(input logic [31:0] a0, input logic [31:0] a1);
      logic [31:0] y, z, sum;
      y = a0; z = a1; sum = 32'h0;
      for (int i = 0; i < 32; i++) begin
         sum = sum + 32'h9E3779B9;
         y = y + (((z << 4) + 32'h0) ^ (z + sum) ^ ((z >> 5) + 32'h0));
         z = z + (((y << 4) + 32'h0) ^ (y + sum) ^ ((y >> 5) + 32'h0));
      end
      return {y, z};
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Stream words hold byte k at [8k+7:8k]; result is the expected output stream word.
   function automatic logic [63:0] expect_out(input logic [63:0] p);
      logic [63:0] c;
`ifdef TEA_FEEDER_BE_EN
      c = tea_enc(bswap(p[31:0]), bswap(p[63:32]));
      return {bswap(c[31:0]), bswap(c[63:32])};
`else
      c = tea_enc(p[31:0], p[63:32]);
      return {c[31:0], c[63:32]};
`endif
   endfunction

   logic [63:0] core_pipe [TEA_LAT];
   always @(posedge clk) begin
      core_pipe[0] <= tea_enc(tea_v0_in, tea_v1_in);
      for (int i = 1; i < TEA_LAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign tea_v0_out = core_pipe[TEA_LAT-1][63:32];
   assign tea_v1_out = core_pipe[TEA_LAT-1][31:0];

   int         cyc = 0;
   int         issue_cnt = 0;
   int         valid_cnt = 0;
   int         rise_cyc = -1;
   logic       prev_valid = 1'b0;
   logic [7:0] rx_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (nrst && out_valid && out_ready) rx_q.push_back(out_byte);
      if ((tea_v0_in != 32'h0) || (tea_v1_in != 32'h0)) issue_cnt <= issue_cnt + 1;
      if (out_valid) valid_cnt <= valid_cnt + 1;
      if (out_valid && !prev_valid) rise_cyc <= cyc;
      prev_valid <= out_valid;
   end

   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      in_byte = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] p);
      for (int k = 0; k < 8; k++) send_byte(p[8*k +: 8]);
      exp_q.push_back(expect_out(p));
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int t = 0;
      while (rx_q.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, 64'(rx_q.size()), 64'(n));
   endtask

   function automatic logic [63:0] get_word(input int base);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < 8; k++)
         if (base + k < rx_q.size()) w[8*k +: 8] = rx_q[base + k];
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pats [6];
      logic [63:0] p;
      logic [63:0] w;
      logic [63:0] c_t1;
      logic [7:0]  held_b;
      logic        hold;
      int          base;
      int          acc_cyc;
      int          iss_base;
      int          vbase;

      pats[0] = 64'h0706050403020100;
      pats[1] = 64'h0f0e0d0c0b0a0908;
      pats[2] = 64'hdeadbeefcafef00d;
      pats[3] = 64'h0123456789abcdef;
      pats[4] = 64'hffffffffffffffff;
      pats[5] = 64'h8000000000000001;
`ifdef TEA_FEEDER_BE_EN
      c_t1 = 64'h40a9ba940a3aea41;
`else
      c_t1 = 64'h94baa94041ea3a0a;
`endif

      nrst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
      #2 nrst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_byte", 64'(out_byte), 64'd0);
      check("rst_v_in", {tea_v0_in, tea_v1_in}, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_credits", 64'(dut.credits_q), 64'd4);
      repeat (2) @(posedge clk);
      @(negedge clk) nrst = 1'b1;
      @(posedge clk); #1;

      // Known-answer vector and first-output latency.
      out_ready = 1'b1;
      base = rx_q.size();
      exp_q.delete();
      send_block(64'h0);
      acc_cyc = cyc;
      check("t1_busy", 64'(busy), 64'd1);
      wait_rx(base + 8, 200, "t1_rx_count");
      check("t1_word", get_word(base), c_t1);
      check("t1_latency", 64'(rise_cyc - acc_cyc), 64'(TEA_LAT + 3));
      repeat (3) @(negedge clk);
      check("t1_credits", 64'(dut.credits_q), 64'd4);
      check("t1_idle", 64'(busy), 64'd0);

      // Six blocks against a stalled sink: credits cap issue at four.
      @(posedge clk); #1;
      out_ready = 1'b0;
      base = rx_q.size();
      exp_q.delete();
      iss_base = issue_cnt;
      for (int b = 0; b < 5; b++) send_block(pats[b]);
      in_byte = pats[5][7:0];
      in_valid = 1'b1;
      repeat (50) @(negedge clk);
      w = exp_q[0];
      check("t2_in_ready_low", 64'(in_ready), 64'd0);
      check("t2_issued", 64'(issue_cnt - iss_base), 64'd4);
      check("t2_credits_zero", 64'(dut.credits_q), 64'd0);
      check("t2_fifo_cnt", 64'(dut.cnt_q), 64'd3);
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_out_byte0", 64'(out_byte), 64'(w[7:0]));
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_byte(pats[5][7:0]);
      check("t5_pending_issued", 64'(issue_cnt - iss_base), 64'd5);
      check("t5_credits_stay0", 64'(dut.credits_q), 64'd0);
      p = pats[5];
      for (int k = 1; k < 8; k++) send_byte(p[8*k +: 8]);
      exp_q.push_back(expect_out(p));
      wait_rx(base + 48, 800, "t2_rx_count");
      for (int i = 0; i < 6; i++)
         check($sformatf("t2_word%0d", i), get_word(base + 8*i), exp_q[i]);
      repeat (3) @(negedge clk);
      check("t2_credits_back", 64'(dut.credits_q), 64'd4);
      check("t2_idle", 64'(busy), 64'd0);

      // Toggling sink: held bytes must stay put.
      @(posedge clk); #1;
      base = rx_q.size();
      exp_q.delete();
      send_block(64'h1122334455667788);
      hold = 1'b0;
      held_b = 8'h00;
      out_ready = 1'b1;
      for (int i = 0; i < 400 && rx_q.size() < base + 8; i++) begin
         @(negedge clk);
         if (hold) begin
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_byte", 64'(out_byte), 64'(held_b));
         end
         hold = out_valid && !out_ready;
         held_b = out_byte;
         @(posedge clk); #1;
         out_ready = !out_ready;
      end
      out_ready = 1'b1;
      wait_rx(base + 8, 20, "t3_rx_count");
      check("t3_word", get_word(base), exp_q[0]);
      repeat (3) @(negedge clk);
      check("t3_credits_back", 64'(dut.credits_q), 64'd4);

      // Reset with two blocks in flight and a partial block packed.
      @(posedge clk); #1;
      exp_q.delete();
      send_block(64'haaaaaaaa55555555);
      send_block(64'h0badf00d12345678);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("t4_busy_before", 64'(busy), 64'd1);
      nrst = 1'b0;
      #1;
      check("t4_in_ready", 64'(in_ready), 64'd1);
      check("t4_out_valid", 64'(out_valid), 64'd0);
      check("t4_out_byte", 64'(out_byte), 64'd0);
      check("t4_v_in", {tea_v0_in, tea_v1_in}, 64'd0);
      check("t4_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) nrst = 1'b1;
      base = rx_q.size();
      vbase = valid_cnt;
      repeat (60) @(negedge clk);
      check("t4_no_stale_bytes", 64'(rx_q.size()), 64'(base));
      check("t4_no_out_valid", 64'(valid_cnt - vbase), 64'd0);
      check("t4_credits", 64'(dut.credits_q), 64'd4);
      @(posedge clk); #1;
      exp_q.delete();
      send_block(64'h0011223344556677);
      wait_rx(base + 8, 200, "t4_rx_count");
      check("t4_word", get_word(base), exp_q[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
